// File: rtl/arbiter.sv
// Two-requester fixed-priority arbiter with sticky grants.
// Requester 0 wins from idle; an active grant is held until its owner drops its request.
module arbiter (
  input  logic clock,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  output logic gnt_0,
  output logic gnt_1
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  // State register; grants get their own flops loaded from the next-state decode,
  // so they are glitch-free and can never both be high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt_0 <= 1'b0;
      gnt_1 <= 1'b0;
    end else begin
      state <= state_next;
      gnt_0 <= (state_next == GNT0);
      gnt_1 <= (state_next == GNT1);
    end
  end

  // Next-state logic; any illegal encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (req_0)      state_next = GNT0;
        else if (req_1) state_next = GNT1;
        else            state_next = IDLE;
      end
      GNT0: begin
        if (req_0)      state_next = GNT0;
        else if (req_1) state_next = GNT1;
        else            state_next = IDLE;
      end
      GNT1: begin
        if (req_1)      state_next = GNT1;
        else if (req_0) state_next = GNT0;
        else            state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for arbiter: vector table, async-reset corner cases and
// a random run against a reference model, with expected grants queued at drive time.
module tb_arbiter;

  logic clock;
  logic reset;
  logic req_0;
  logic req_1;
  logic gnt_0;
  logic gnt_1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic r0;
    logic r1;
    logic g0;
    logic g1;
  } vec_t;

  typedef struct {
    logic g0;
    logic g1;
  } exp_t;

  exp_t exp_q[$];
  int   model_state;  // 0 idle, 1 gnt0, 2 gnt1
  logic prev_r0;
  logic prev_r1;

  arbiter dut (
    .clock(clock),
    .reset(reset),
    .req_0(req_0),
    .req_1(req_1),
    .gnt_0(gnt_0),
    .gnt_1(gnt_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic int model_next(input int s, input logic r0, input logic r1);
    case (s)
      1:       return r0 ? 1 : (r1 ? 2 : 0);
      2:       return r1 ? 2 : (r0 ? 1 : 0);
      default: return r0 ? 1 : (r1 ? 2 : 0);
    endcase
  endfunction

  // Drive on the falling edge, push the model's prediction, compare after the rising edge.
  task automatic step(input logic r0, input logic r1, input string name);
    exp_t e;
    exp_t got;
    @(negedge clock);
    req_0 = r0;
    req_1 = r1;
    model_state = model_next(model_state, r0, r1);
    e.g0 = (model_state == 1);
    e.g1 = (model_state == 2);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = exp_q.pop_front();
      check({name, ".gnt_0"}, gnt_0, got.g0);
      check({name, ".gnt_1"}, gnt_1, got.g1);
    end
  endtask

  task automatic check_table_row(input vec_t v, input int idx);
    // The table holds hand-derived expectations; cross-check them against the model too.
    step(v.r0, v.r1, $sformatf("vec%0d", idx));
    check($sformatf("vec%0d.tbl_g0", idx), gnt_0, v.g0);
    check($sformatf("vec%0d.tbl_g1", idx), gnt_1, v.g1);
  endtask

  vec_t vecs[$];

  initial begin
    // {req_0, req_1} driven before an edge, {gnt_0, gnt_1} expected after it.
    vecs = '{
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0},  // single-cycle pulse on req_0
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0},  // simultaneous from idle: 0 wins
      '{1'b0, 1'b1, 1'b0, 1'b1},  // handover 0 -> 1
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1},  // req_0 does not preempt
      '{1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0},  // handover 1 -> 0
      '{1'b1, 1'b1, 1'b1, 1'b0},  // req_1 does not preempt
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},  // single-cycle pulse on req_1
      '{1'b0, 1'b0, 1'b0, 1'b0}
    };

    model_state = 0;
    reset = 1'b0;
    req_0 = 1'b1;
    req_1 = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hold.gnt_0", gnt_0, 1'b0);
    check("reset_hold.gnt_1", gnt_1, 1'b0);

    @(negedge clock);
    req_0 = 1'b0;
    req_1 = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) check_table_row(vecs[i], i);

    // Reset asserted mid-grant must drop gnt_0 before the next rising edge.
    step(1'b1, 1'b0, "pre_async");
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset.gnt_0", gnt_0, 1'b0);
    check("async_reset.gnt_1", gnt_1, 1'b0);
    model_state = 0;
    @(negedge clock);
    req_0 = 1'b0;
    reset = 1'b1;
    step(1'b0, 1'b0, "post_reset_idle");

    // Random run: model match, mutual exclusion, grant preceded by its request.
    prev_r0 = 1'b0;
    prev_r1 = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      logic r0;
      logic r1;
      r0 = 1'(($urandom_range(0, 99) < 55) ? 1 : 0);
      r1 = 1'(($urandom_range(0, 99) < 55) ? 1 : 0);
      step(r0, r1, "rand");
      checks++;
      if (gnt_0 && gnt_1) begin
        errors++;
        $display("FAIL mutex: gnt_0=%b gnt_1=%b, expected not both at cycle %0d", gnt_0, gnt_1, i);
      end
      checks++;
      if ((gnt_0 && !r0) || (gnt_1 && !r1)) begin
        errors++;
        $display("FAIL grant_without_req: gnt=%b%b req=%b%b at cycle %0d", gnt_0, gnt_1, r0, r1, i);
      end
      prev_r0 = r0;
      prev_r1 = r1;
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
